// File: rtl/can_tail_pkg.sv
// Shared definitions for the CAN frame-tail transmitter and its bit counter.
package can_tail_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CRC_DEL,
    ACK_SLOT,
    ACK_DEL,
    EOF,
    ERR_FLAG,
    ERR_WAIT,
    ERR_DEL,
    IFS
  } state_t;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  localparam int EOF_BITS_DEF   = 7;
  localparam int IFS_BITS_DEF   = 3;
  localparam int FLAG_BITS_DEF  = 6;
  localparam int DELIM_BITS_DEF = 8;
  localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/can_bit_counter.sv
// Bit-time up-counter: synchronous clear, per-bit enable and terminal-count compare.
module can_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/can_tail_tx.sv
// CAN frame-tail sequencer: CRC delimiter through intermission, with error flag/delimiter on fault.
module can_tail_tx
  import can_tail_pkg::*;
#(
  parameter int EOF_BITS   = EOF_BITS_DEF,
  parameter int IFS_BITS   = IFS_BITS_DEF,
  parameter int FLAG_BITS  = FLAG_BITS_DEF,
  parameter int DELIM_BITS = DELIM_BITS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic TP,
  input  logic SP,
  input  logic start,
  input  logic err_passive,
  input  logic RX,
  output logic TX,
  output logic busy,
  output logic EOF_Flag,
  output logic ACK_Error,
  output logic Form_Error,
  output logic done
);

  localparam logic [CNT_W-1:0] EOF_LAST   = CNT_W'(EOF_BITS - 1);
  localparam logic [CNT_W-1:0] IFS_LAST   = CNT_W'(IFS_BITS - 1);
  localparam logic [CNT_W-1:0] FLAG_LAST  = CNT_W'(FLAG_BITS - 1);
  localparam logic [CNT_W-1:0] DELIM_LAST = CNT_W'(DELIM_BITS - 2);

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tx_q, tx_d;
  logic             eof_q, eof_d;
  logic             ack_err_q, ack_err_d;
  logic             form_err_q, form_err_d;
  logic             rx_s_q, rx_s_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_last;

  can_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .last_i (cnt_last),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_d       = tx_q;
    ack_err_d  = ack_err_q;
    form_err_d = form_err_q;
    rx_s_d     = rx_s_q;
    cnt_en     = 1'b0;

    case (state_q)
      EOF:      cnt_last = EOF_LAST;
      ERR_FLAG: cnt_last = FLAG_LAST;
      ERR_DEL:  cnt_last = DELIM_LAST;
      IFS:      cnt_last = IFS_LAST;
      default:  cnt_last = '0;
    endcase

    if (start && (state_q == IDLE)) begin
      pend_d     = 1'b1;
      busy_d     = 1'b1;
      ack_err_d  = 1'b1;
      form_err_d = 1'b1;
    end

    // Errors flag immediately at SP; the state reacts at the following TP.
    if (SP) begin
      rx_s_d = RX;
      case (state_q)
        CRC_DEL, ACK_DEL, EOF: if (RX == DOMINANT) form_err_d = 1'b0;
        ACK_SLOT:              if (RX == RECESSIVE) ack_err_d = 1'b0;
        default: ;
      endcase
    end

    if (TP) begin
      rx_s_d = RECESSIVE;
      case (state_q)
        IDLE: begin
          if (pend_d) begin
            state_d = CRC_DEL;
            pend_d  = 1'b0;
          end
        end
        CRC_DEL:  state_d = rx_s_q ? ACK_SLOT : ERR_FLAG;
        ACK_SLOT: state_d = rx_s_q ? ERR_FLAG : ACK_DEL;
        ACK_DEL:  state_d = rx_s_q ? EOF : ERR_FLAG;
        EOF: begin
          cnt_en = 1'b1;
          if (!rx_s_q)     state_d = ERR_FLAG;
          else if (cnt_tc) state_d = IFS;
        end
        ERR_FLAG: begin
          cnt_en = 1'b1;
          if (cnt_tc) state_d = ERR_WAIT;
        end
        ERR_WAIT: if (rx_s_q) state_d = ERR_DEL;
        ERR_DEL: begin
          cnt_en = 1'b1;
          if (!rx_s_q)     state_d = ERR_FLAG;
          else if (cnt_tc) state_d = IFS;
        end
        IFS: begin
          cnt_en = 1'b1;
          if (!rx_s_q || cnt_tc) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
      tx_d = (state_d == ERR_FLAG) ? err_passive : RECESSIVE;
    end

    eof_d   = (state_d != EOF);
    cnt_clr = TP && (state_d != state_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_q       <= RECESSIVE;
      eof_q      <= 1'b1;
      ack_err_q  <= 1'b1;
      form_err_q <= 1'b1;
      rx_s_q     <= RECESSIVE;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_q       <= tx_d;
      eof_q      <= eof_d;
      ack_err_q  <= ack_err_d;
      form_err_q <= form_err_d;
      rx_s_q     <= rx_s_d;
    end
  end

  assign TX         = tx_q;
  assign busy       = busy_q;
  assign EOF_Flag   = eof_q;
  assign ACK_Error  = ack_err_q;
  assign Form_Error = form_err_q;
  assign done       = done_q;

endmodule

// File: tb/tb_can_tail_tx.sv
// Directed bench for can_tail_tx: per-bit expectations queued, then popped after each TP.
module tb_can_tail_tx;

  localparam int EOF_N   = 7;
  localparam int IFS_N   = 3;
  localparam int FLAG_N  = 6;
  localparam int DELIM_N = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic TP = 1'b0;
  logic SP = 1'b0;
  logic start = 1'b0;
  logic err_passive = 1'b0;
  logic RX = 1'b1;
  logic TX, busy, EOF_Flag, ACK_Error, Form_Error, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic tx;
    logic eof;
    logic dn;
    logic bsy;
  } exp_t;

  exp_t exp_q[$];

  can_tail_tx dut (
    .clk         (clk),
    .reset       (reset),
    .TP          (TP),
    .SP          (SP),
    .start       (start),
    .err_passive (err_passive),
    .RX          (RX),
    .TX          (TX),
    .busy        (busy),
    .EOF_Flag    (EOF_Flag),
    .ACK_Error   (ACK_Error),
    .Form_Error  (Form_Error),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic push(input logic tx, input logic eof, input logic dn, input logic bsy,
                      input int n);
    exp_t e;
    e.tx = tx; e.eof = eof; e.dn = dn; e.bsy = bsy;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // One bit time: TP on the first clk, SP mid-bit; outputs sampled on falling edges.
  task automatic run_bit(input logic rx, input logic st);
    exp_t e;
    @(negedge clk); TP = 1'b1; RX = rx; start = st;
    @(negedge clk); TP = 1'b0; start = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed 0 entries expected at least 1");
      e = '0;
    end else begin
      e = exp_q.pop_front();
      chk("TX", TX, e.tx);
      chk("EOF_Flag", EOF_Flag, e.eof);
      chk("done", done, e.dn);
      chk("busy", busy, e.bsy);
    end
    @(negedge clk); @(negedge clk); SP = 1'b1;
    @(negedge clk); SP = 1'b0;
    chk("done_mid", done, 1'b0);
    chk("TX_mid", TX, e.tx);
    repeat (3) @(negedge clk);
  endtask

  task automatic bits(input logic rx, input int n);
    for (int i = 0; i < n; i++) run_bit(rx, 1'b0);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("ACK_Error_cleared", ACK_Error, 1'b1);
    chk("Form_Error_cleared", Form_Error, 1'b1);
  endtask

  task automatic clean_frame();
    do_start();
    push(1, 1, 0, 1, 3);
    push(1, 0, 0, 1, EOF_N);
    push(1, 1, 0, 1, IFS_N);
    push(1, 1, 1, 0, 1);
    run_bit(1, 0); run_bit(0, 0); run_bit(1, 0);
    bits(1, EOF_N);
    bits(1, IFS_N);
    run_bit(1, 0);
    chk("clean_ACK_Error", ACK_Error, 1'b1);
    chk("clean_Form_Error", Form_Error, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_TX", TX, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_EOF_Flag", EOF_Flag, 1'b1);
    chk("rst_ACK_Error", ACK_Error, 1'b1);
    chk("rst_Form_Error", Form_Error, 1'b1);
    chk("rst_done", done, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Clean frame
    clean_frame();

    // Missing ACK: 6 dominant flag bits, 8 recessive delimiter bits, 3 IFS
    do_start();
    push(1, 1, 0, 1, 2);
    push(0, 1, 0, 1, FLAG_N);
    push(1, 1, 0, 1, DELIM_N);
    push(1, 1, 0, 1, IFS_N);
    push(1, 1, 1, 0, 1);
    run_bit(1, 0); run_bit(1, 0);
    chk("noack_ACK_Error", ACK_Error, 1'b0);
    bits(0, FLAG_N);
    bits(1, DELIM_N);
    bits(1, IFS_N);
    run_bit(1, 0);
    chk("noack_ACK_Error_sticky", ACK_Error, 1'b0);
    chk("noack_Form_Error", Form_Error, 1'b1);

    // Dominant 4th EOF bit, error-active
    do_start();
    push(1, 1, 0, 1, 3);
    push(1, 0, 0, 1, 4);
    push(0, 1, 0, 1, FLAG_N);
    push(1, 1, 0, 1, DELIM_N);
    push(1, 1, 0, 1, IFS_N);
    push(1, 1, 1, 0, 1);
    run_bit(1, 0); run_bit(0, 0); run_bit(1, 0);
    bits(1, 3);
    run_bit(0, 0);
    chk("eof4_Form_Error", Form_Error, 1'b0);
    bits(0, FLAG_N);
    bits(1, DELIM_N);
    bits(1, IFS_N);
    run_bit(1, 0);
    chk("eof4_Form_Error_sticky", Form_Error, 1'b0);
    chk("eof4_ACK_Error", ACK_Error, 1'b1);

    // Same, error-passive: flag stays recessive
    err_passive = 1'b1;
    do_start();
    push(1, 1, 0, 1, 3);
    push(1, 0, 0, 1, 4);
    push(1, 1, 0, 1, FLAG_N);
    push(1, 1, 0, 1, DELIM_N);
    push(1, 1, 0, 1, IFS_N);
    push(1, 1, 1, 0, 1);
    run_bit(1, 0); run_bit(0, 0); run_bit(1, 0);
    bits(1, 3);
    run_bit(0, 0);
    bits(1, FLAG_N);
    bits(1, DELIM_N);
    bits(1, IFS_N);
    run_bit(1, 0);
    chk("passive_Form_Error", Form_Error, 1'b0);
    err_passive = 1'b0;

    // Overlapping flags: RX dominant for 3 bits after own flag
    do_start();
    push(1, 1, 0, 1, 2);
    push(0, 1, 0, 1, FLAG_N);
    push(1, 1, 0, 1, 3 + DELIM_N);
    push(1, 1, 0, 1, IFS_N);
    push(1, 1, 1, 0, 1);
    run_bit(1, 0); run_bit(1, 0);
    bits(0, FLAG_N);
    bits(0, 3);
    bits(1, DELIM_N);
    bits(1, IFS_N);
    run_bit(1, 0);
    chk("overlap_Form_Error", Form_Error, 1'b1);

    // start with TP in the same clk; dominant 2nd IFS bit ends the tail early
    push(1, 1, 0, 1, 3);
    push(1, 0, 0, 1, EOF_N);
    push(1, 1, 0, 1, 2);
    push(1, 1, 1, 0, 1);
    run_bit(1, 1); run_bit(0, 0); run_bit(1, 0);
    bits(1, EOF_N);
    run_bit(1, 0); run_bit(0, 0);
    run_bit(1, 0);
    chk("early_ifs_Form_Error", Form_Error, 1'b1);

    // Reset during EOF bit 3
    do_start();
    push(1, 1, 0, 1, 3);
    push(1, 0, 0, 1, 3);
    run_bit(1, 0); run_bit(0, 0); run_bit(1, 0);
    bits(1, 3);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("midrst_TX", TX, 1'b1);
    chk("midrst_EOF_Flag", EOF_Flag, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    clean_frame();

    chk("scoreboard_drained", exp_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
